s0_rs_enc: RTL and testbench
============================

# s0_rs_enc

Systematic Reed-Solomon encoder over GF(2^8) producing 4 parity symbols (t=2) per frame: the transmit-side counterpart of the s1 syndrome / s2 KES decoder chain. It accepts K message symbols on a valid/ready stream, passes them through unchanged, then appends parity p3..p0 from a 4-stage LFSR. Downstream backpressure stalls the encoder with no data loss.

## Interface
Parameters:
- K, 251: message symbols per frame; legal range 1..251, so N = K+4 ≤ 255.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_vld  in  1  message symbol valid.
- in_sym  in  8  message symbol; the first symbol is the highest-degree coefficient.
- in_rdy  out  1  encoder accepts `in_sym` this cycle.
- out_vld  out  1  output symbol valid.
- out_sym  out  8  codeword symbol.
- out_sop  out  1  first symbol of the codeword.
- out_eop  out  1  last symbol of the codeword (p0).
- out_par  out  1  current symbol is parity.
- out_rdy  in  1  downstream accepts the output this cycle.

## Operation
- Field: primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D).
- Generator: g(x) = (x+α^0)(x+α^1)(x+α^2)(x+α^3) = x^4 + 0x0F·x^3 + 0x36·x^2 + 0x78·x + 0x40.
- Syndrome roots α^0..α^3 are shared with the decoder.
- Output-register advance: `adv = out_rdy | ~out_vld`.
- Handshake: `in_rdy = (state != PAR) & adv`. An input is accepted when `in_vld & in_rdy`.
- States are one-hot, IDLE / MSG / PAR.
- **IDLE**
  - Parity regs r0..r3 = 0 and symbol counter cnt = 0.
  - On accept: go to MSG, unless K == 1, in which case go directly to PAR.
- **MSG**
  - Each accept: fb = in_sym ^ r3; r3←r2^(0x0F·fb); r2←r1^(0x36·fb); r1←r0^(0x78·fb); r0←0x40·fb; cnt←cnt+1.
  - On the accept that makes cnt = K−1 (the K-th symbol): go to PAR and set cnt←0.
- **PAR**
  - `in_rdy = 0`.
  - Each `adv` cycle: load r3 into the output register, shift r3←r2, r2←r1, r1←r0, r0←0, and increment cnt.
  - After the 4th parity load (cnt = 3): clear r0..r3 and cnt, and go to IDLE.
- **Output register**, loaded only when `adv`:
  - Message accept: out_sym = in_sym; out_par = 0; out_sop = 1 iff it is the frame's first symbol.
  - Parity load: out_par = 1; out_eop = 1 on the 4th parity symbol.
  - If `adv` and nothing is loaded, out_vld←0.
- A frame is strictly K message symbols followed by 4 parity symbols. Input gaps (`in_vld = 0`) are allowed mid-frame and hold all state.
- Arithmetic: GF multiplies are by constants; additions are XOR. cnt is 8 bits.

## Timing
- Reset values: out_vld = 0, out_sym = 0, out_sop = out_eop = out_par = 0, in_rdy = 0 during reset, state = IDLE, r0..r3 = 0, cnt = 0.
- Latency:
  - A symbol accepted at cycle t appears on `out_*` at t+1 if out_rdy holds.
  - The first parity symbol appears the cycle after the K-th symbol is presented (the K-th symbol itself is loaded at that cycle).
  - With no stall, a frame occupies K+4 output cycles. Throughput is 1 symbol/cycle during message.
- The next frame's first symbol can be accepted in the same cycle that p0 is accepted downstream: the IDLE state is combinationally ready. `in_rdy` is asserted in IDLE when `adv`. Zero bubble between frames, except for the 4 parity cycles.
- Stall (`out_rdy = 0` with `out_vld = 1`): output register, LFSR, cnt and state all hold; in_rdy = 0.
- Reset mid-frame, sampled at a clock edge: the partial frame is discarded, all registers return to reset values, and the next accepted symbol starts a new frame with out_sop = 1.

## Structure
- Package `rs_pkg`:
  - Constants RS_G0..RS_G3 (0x40, 0x78, 0x36, 0x0F).
  - RS_PRIM = 0x11D.
  - RS_NPAR = 4.
  - State encodings S_IDLE / S_MSG / S_PAR.
- Sub-module: reuse the existing `gf2m8_multi`, four instances with `y` tied to the RS_Gx constants and `x = fb`.
- No clock gating in this block.

## Test plan
- K=4, message 00 00 00 00, out_rdy=1 → output 00 00 00 00 00 00 00 00; sop on the 1st symbol, par on symbols 5-8, eop on the 8th.
- K=4, message 00 00 00 01 → parity 0x0F 0x36 0x78 0x40 in that order.
- K=251, random messages, out_rdy=1 → every output codeword evaluates to 0 at α^0..α^3, and running it through the s1/s2 decoder chain yields zero syndromes.
- Random out_rdy toggling (~50%) and random in_vld gaps → output stream bit-identical to the no-stall reference; no symbol dropped or duplicated; no in_rdy while in PAR.
- Back-to-back frames with in_vld held high → new-frame sop immediately follows eop, no gap cycle.
- rst pulsed after symbol 2 of a frame → out_vld = 0 next cycle; the following frame encodes correctly from sop.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared constants and GF(2^8) helpers for the RS(N, N-4) encoder/decoder chain.
package rs_pkg;

   localparam int unsigned RS_M    = 8;
   localparam int unsigned RS_NPAR = 4;

   localparam logic [8:0] RS_PRIM = 9'h11D;

   // g(x) = x^4 + G3 x^3 + G2 x^2 + G1 x + G0, roots alpha^0..alpha^3
   localparam logic [7:0] RS_G0 = 8'h40;
   localparam logic [7:0] RS_G1 = 8'h78;
   localparam logic [7:0] RS_G2 = 8'h36;
   localparam logic [7:0] RS_G3 = 8'h0F;

   // One-hot encoder states
   localparam logic [2:0] S_IDLE = 3'b001;
   localparam logic [2:0] S_MSG  = 3'b010;
   localparam logic [2:0] S_PAR  = 3'b100;

   // Shift-and-add multiply in GF(2^8) reduced by RS_PRIM
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = sh[7] ? (8'(sh << 1) ^ RS_PRIM[7:0]) : 8'(sh << 1);
      end
      return acc;
   endfunction

endpackage

// File: rtl/gf2m8_multi.sv
// Combinational GF(2^8) multiplier, z_c = x * y mod 0x11D.
module gf2m8_multi
   import rs_pkg::*;
(
   input  logic [7:0] x,
   input  logic [7:0] y,
   output logic [7:0] z_c
);

   // Field product
   always_comb z_c = gf_mul(x, y);

endmodule

// File: rtl/s0_rs_enc.sv
// Systematic RS encoder: passes K message symbols through, then appends p3..p0.
module s0_rs_enc
   import rs_pkg::*;
#(
   parameter int unsigned K = 251
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_vld,
   input  logic [7:0] in_sym,
   output logic       in_rdy,
   output logic       out_vld,
   output logic [7:0] out_sym,
   output logic       out_sop,
   output logic       out_eop,
   output logic       out_par,
   input  logic       out_rdy
);

   localparam logic [7:0] CNT_LAST = 8'(K - 1);
   localparam logic [7:0] PAR_LAST = 8'(RS_NPAR - 1);

   logic [2:0] state, state_nxt;
   logic [7:0] r0, r1, r2, r3;
   logic [7:0] r0_nxt, r1_nxt, r2_nxt, r3_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic       out_vld_nxt, out_sop_nxt, out_eop_nxt, out_par_nxt;
   logic [7:0] out_sym_nxt;

   logic       adv_c;
   logic       acc_c;
   logic [7:0] fb_c;
   logic [7:0] gm_c [RS_NPAR];

   assign adv_c  = out_rdy | ~out_vld;
   assign in_rdy = ~rst & (state != S_PAR) & adv_c;
   assign acc_c  = in_vld & in_rdy;
   assign fb_c   = in_sym ^ r3;

   gf2m8_multi u_mul0 (.x(fb_c), .y(RS_G0), .z_c(gm_c[0]));
   gf2m8_multi u_mul1 (.x(fb_c), .y(RS_G1), .z_c(gm_c[1]));
   gf2m8_multi u_mul2 (.x(fb_c), .y(RS_G2), .z_c(gm_c[2]));
   gf2m8_multi u_mul3 (.x(fb_c), .y(RS_G3), .z_c(gm_c[3]));

   // Next state: LFSR update on message accept, parity drain in PAR
   always_comb begin
      state_nxt   = state;
      r0_nxt      = r0;
      r1_nxt      = r1;
      r2_nxt      = r2;
      r3_nxt      = r3;
      cnt_nxt     = cnt;
      out_vld_nxt = out_vld;
      out_sym_nxt = out_sym;
      out_sop_nxt = out_sop;
      out_eop_nxt = out_eop;
      out_par_nxt = out_par;

      if (adv_c) out_vld_nxt = 1'b0;

      case (state)
         S_IDLE, S_MSG: begin
            if (acc_c) begin
               r3_nxt      = r2 ^ gm_c[3];
               r2_nxt      = r1 ^ gm_c[2];
               r1_nxt      = r0 ^ gm_c[1];
               r0_nxt      = gm_c[0];
               out_vld_nxt = 1'b1;
               out_sym_nxt = in_sym;
               out_sop_nxt = (state == S_IDLE);
               out_eop_nxt = 1'b0;
               out_par_nxt = 1'b0;
               if (cnt == CNT_LAST) begin
                  state_nxt = S_PAR;
                  cnt_nxt   = 8'd0;
               end else begin
                  state_nxt = S_MSG;
                  cnt_nxt   = cnt + 8'd1;
               end
            end
         end
         S_PAR: begin
            if (adv_c) begin
               out_vld_nxt = 1'b1;
               out_sym_nxt = r3;
               out_sop_nxt = 1'b0;
               out_eop_nxt = (cnt == PAR_LAST);
               out_par_nxt = 1'b1;
               r3_nxt      = r2;
               r2_nxt      = r1;
               r1_nxt      = r0;
               r0_nxt      = 8'h00;
               if (cnt == PAR_LAST) begin
                  r3_nxt    = 8'h00;
                  r2_nxt    = 8'h00;
                  r1_nxt    = 8'h00;
                  cnt_nxt   = 8'd0;
                  state_nxt = S_IDLE;
               end else begin
                  cnt_nxt = cnt + 8'd1;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
            r0_nxt    = 8'h00;
            r1_nxt    = 8'h00;
            r2_nxt    = 8'h00;
            r3_nxt    = 8'h00;
            cnt_nxt   = 8'd0;
         end
      endcase
   end

   // State, LFSR and output register
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         r0      <= 8'h00;
         r1      <= 8'h00;
         r2      <= 8'h00;
         r3      <= 8'h00;
         cnt     <= 8'd0;
         out_vld <= 1'b0;
         out_sym <= 8'h00;
         out_sop <= 1'b0;
         out_eop <= 1'b0;
         out_par <= 1'b0;
      end else begin
         state   <= state_nxt;
         r0      <= r0_nxt;
         r1      <= r1_nxt;
         r2      <= r2_nxt;
         r3      <= r3_nxt;
         cnt     <= cnt_nxt;
         out_vld <= out_vld_nxt;
         out_sym <= out_sym_nxt;
         out_sop <= out_sop_nxt;
         out_eop <= out_eop_nxt;
         out_par <= out_par_nxt;
      end
   end

endmodule

// File: tb/tb_s0_rs_enc.sv
// Directed self-checking bench for s0_rs_enc with K = 4.
module tb_s0_rs_enc;

   localparam int unsigned K = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_vld = 1'b0;
   logic [7:0] in_sym = 8'h00;
   logic       in_rdy;
   logic       out_vld;
   logic [7:0] out_sym;
   logic       out_sop;
   logic       out_eop;
   logic       out_par;
   logic       out_rdy = 1'b1;

   int checks = 0;
   int failures = 0;
   bit rand_rdy = 1'b0;

   logic [7:0] cap_sym [$];
   logic [2:0] cap_flg [$];   // {sop, par, eop}
   int         cap_cyc [$];
   int         cyc = 0;
   int         acc_n = 0;
   bit         pending = 1'b0;
   int         rdy_viol = 0;

   s0_rs_enc #(.K(K)) dut (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_sym(in_sym), .in_rdy(in_rdy),
      .out_vld(out_vld), .out_sym(out_sym), .out_sop(out_sop), .out_eop(out_eop),
      .out_par(out_par), .out_rdy(out_rdy)
   );

   always #5 clk = ~clk;

   // Downstream ready: constant or ~50% random
   initial forever begin
      @(posedge clk);
      #1;
      out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor on the falling edge: capture transfers, watch for in_rdy during parity
   always @(negedge clk) begin
      if (rst) begin
         acc_n   = 0;
         pending = 1'b0;
      end else begin
         if (in_rdy && pending && !(out_vld && out_eop)) rdy_viol++;
         if (out_vld && out_rdy) begin
            cap_sym.push_back(out_sym);
            cap_flg.push_back({out_sop, out_par, out_eop});
            cap_cyc.push_back(cyc);
            if (out_eop) pending = 1'b0;
         end
         if (in_vld && in_rdy) begin
            acc_n++;
            if (acc_n == K) begin
               pending = 1'b1;
               acc_n = 0;
            end
         end
      end
      cyc++;
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] s = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= s;
         s = s[7] ? (8'(s << 1) ^ 8'h1D) : 8'(s << 1);
      end
      return p;
   endfunction

   task automatic send_frame(input logic [7:0] m [K], input bit gaps, input bit hold, output bit ok);
      bit got;
      ok = 1'b1;
      for (int i = 0; i < K; i++) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            in_vld = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         in_vld = 1'b1;
         in_sym = m[i];
         got = 1'b0;
         for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            got = in_rdy;
            @(posedge clk);
            #1;
         end
         if (!got) ok = 1'b0;
      end
      if (!hold) in_vld = 1'b0;
   endtask

   task automatic wait_cap(input int n, output bit ok);
      for (int c = 0; c < 500 && cap_sym.size() < n; c++) @(posedge clk);
      #1;
      ok = (cap_sym.size() >= n);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_vld = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_out_vld got=%b exp=0", out_vld); end
      checks++;
      if (out_sym !== 8'h00) begin failures++; $display("FAIL reset_out_sym got=%h exp=00", out_sym); end
      checks++;
      if ({out_sop, out_par, out_eop} !== 3'b000) begin
         failures++; $display("FAIL reset_flags got=%b exp=000", {out_sop, out_par, out_eop});
      end
      checks++;
      if (in_rdy !== 1'b0) begin failures++; $display("FAIL reset_in_rdy got=%b exp=0", in_rdy); end
      in_vld = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (in_rdy !== 1'b1) begin failures++; $display("FAIL idle_in_rdy got=%b exp=1", in_rdy); end
   endtask

   task automatic test_parity(input string name, input logic [7:0] m [K], input logic [7:0] p [4], input bit stall);
      int b;
      bit ok;
      logic [7:0] es;
      logic [2:0] ef;
      b = cap_sym.size();
      rand_rdy = stall;
      send_frame(m, stall, 1'b0, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL %s_accept got=timeout exp=accepted", name); end
      wait_cap(b + K + 4, ok);
      rand_rdy = 1'b0;
      checks++;
      if (!ok) begin
         failures++; $display("FAIL %s_count got=%0d exp=%0d", name, cap_sym.size() - b, K + 4);
      end else begin
         for (int i = 0; i < K + 4; i++) begin
            es = (i < K) ? m[i] : p[i - K];
            ef = {i == 0, i >= K, i == K + 3};
            checks++;
            if (cap_sym[b + i] !== es) begin
               failures++; $display("FAIL %s_sym[%0d] got=%h exp=%h", name, i, cap_sym[b + i], es);
            end
            checks++;
            if (cap_flg[b + i] !== ef) begin
               failures++; $display("FAIL %s_flags[%0d] got=%b exp=%b", name, i, cap_flg[b + i], ef);
            end
         end
      end
      checks++;
      if (rdy_viol != 0) begin failures++; $display("FAIL %s_rdy_in_par got=%0d exp=0", name, rdy_viol); end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (cap_sym.size() != b + K + 4) begin
         failures++; $display("FAIL %s_extra got=%0d exp=%0d", name, cap_sym.size() - b, K + 4);
      end
   endtask

   task automatic test_syndrome();
      logic [7:0] m [K];
      logic [7:0] alpha [4];
      logic [7:0] s;
      int b;
      bit ok;
      alpha = '{8'h01, 8'h02, 8'h04, 8'h08};
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < K; i++) m[i] = 8'($urandom_range(0, 255));
         if (f == 0) m = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
         b = cap_sym.size();
         send_frame(m, 1'b0, 1'b0, ok);
         wait_cap(b + K + 4, ok);
         checks++;
         if (!ok) begin
            failures++; $display("FAIL syn_count[%0d] got=%0d exp=%0d", f, cap_sym.size() - b, K + 4);
         end else begin
            for (int j = 0; j < 4; j++) begin
               s = 8'h00;
               for (int i = 0; i < K + 4; i++) s = gmul(s, alpha[j]) ^ cap_sym[b + i];
               checks++;
               if (s !== 8'h00) begin
                  failures++; $display("FAIL syn[%0d] frame=%0d got=%h exp=00", j, f, s);
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] m1 [K];
      logic [7:0] m2 [K];
      logic [7:0] exp2 [8];
      int b;
      bit ok1, ok2, ok;
      m1 = '{8'h00, 8'h00, 8'h00, 8'h01};
      m2 = '{8'h00, 8'h00, 8'h00, 8'h02};
      exp2 = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h1E, 8'h6C, 8'hF0, 8'h80};
      b = cap_sym.size();
      send_frame(m1, 1'b0, 1'b1, ok1);
      send_frame(m2, 1'b0, 1'b0, ok2);
      wait_cap(b + 16, ok);
      checks++;
      if (!(ok && ok1 && ok2)) begin
         failures++; $display("FAIL b2b_count got=%0d exp=16", cap_sym.size() - b);
      end else begin
         checks++;
         if (cap_cyc[b + 8] !== cap_cyc[b + 7] + 1) begin
            failures++; $display("FAIL b2b_gap got=%0d exp=1", cap_cyc[b + 8] - cap_cyc[b + 7]);
         end
         checks++;
         if (cap_cyc[b + 15] - cap_cyc[b] !== 15) begin
            failures++; $display("FAIL b2b_span got=%0d exp=15", cap_cyc[b + 15] - cap_cyc[b]);
         end
         checks++;
         if ({cap_flg[b + 7][0], cap_flg[b + 8][2]} !== 2'b11) begin
            failures++; $display("FAIL b2b_eop_sop got=%b%b exp=11", cap_flg[b + 7][0], cap_flg[b + 8][2]);
         end
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (cap_sym[b + 8 + i] !== exp2[i]) begin
               failures++; $display("FAIL b2b_sym[%0d] got=%h exp=%h", i, cap_sym[b + 8 + i], exp2[i]);
            end
         end
      end
   endtask

   task automatic test_rst_mid();
      logic [7:0] m [K];
      logic [7:0] p [4];
      in_vld = 1'b1;
      in_sym = 8'h11;
      @(posedge clk);
      #1;
      in_sym = 8'h22;
      @(posedge clk);
      #1;
      in_vld = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_vld !== 1'b0) begin failures++; $display("FAIL rst_mid_out_vld got=%b exp=0", out_vld); end
      checks++;
      if (in_rdy !== 1'b0) begin failures++; $display("FAIL rst_mid_in_rdy got=%b exp=0", in_rdy); end
      rst = 1'b0;
      @(posedge clk);
      #1;
      m = '{8'h00, 8'h00, 8'h00, 8'h01};
      p = '{8'h0F, 8'h36, 8'h78, 8'h40};
      test_parity("after_rst", m, p, 1'b0);
   endtask

   initial begin
      logic [7:0] m [K];
      logic [7:0] p [4];
      test_reset();
      m = '{8'h00, 8'h00, 8'h00, 8'h00}; p = '{8'h00, 8'h00, 8'h00, 8'h00};
      test_parity("zero", m, p, 1'b0);
      m = '{8'h00, 8'h00, 8'h00, 8'h01}; p = '{8'h0F, 8'h36, 8'h78, 8'h40};
      test_parity("unit", m, p, 1'b0);
      m = '{8'h00, 8'h00, 8'h00, 8'h03}; p = '{8'h11, 8'h5A, 8'h88, 8'hC0};
      test_parity("three", m, p, 1'b0);
      test_syndrome();
      m = '{8'h00, 8'h00, 8'h00, 8'h01}; p = '{8'h0F, 8'h36, 8'h78, 8'h40};
      test_parity("stall_unit", m, p, 1'b1);
      m = '{8'h00, 8'h00, 8'h00, 8'h03}; p = '{8'h11, 8'h5A, 8'h88, 8'hC0};
      test_parity("stall_three", m, p, 1'b1);
      test_back_to_back();
      test_rst_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
